// File: rtl/i2c_master_tx.sv
// Single-byte I2C write master: START, 7-bit address + W, one data byte, both ACKs, STOP.
// SCL and SDA_OE are registered so the bus pins never glitch on state decode.
module i2c_master_tx #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [6:0]  DEV_ADDR = 7'b1000111
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       SCL,
  output logic       SDA_OE,
  input  logic       SDA_IN
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [15:0]     shift_q, shift_d;
  logic            nack_q, nack_d;
  logic            done_q, done_d;
  logic            scl_q, scl_d;
  logic            sda_oe_q, sda_oe_d;
  logic            tick;
  logic            slot_end;

  assign tick     = (div_q == DivMax);
  assign slot_end = tick && (qtr_q == 2'd3);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    nack_d  = nack_q;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        qtr_d = qtr_q + 2'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          // Address byte sits above the data byte so one shifter serves both.
          shift_d = {DEV_ADDR, 1'b0, din};
          nack_d  = 1'b0;
          div_d   = '0;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (slot_end) begin
          state_d = StAddr;
        end
      end
      StAddr, StData: begin
        if (slot_end) begin
          shift_d = {shift_q[14:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (state_q == StAddr) ? StAddrAck : StDataAck;
          end
        end
      end
      StAddrAck, StDataAck: begin
        if (tick && (qtr_q == 2'd2) && SDA_IN) begin
          nack_d = 1'b1;
        end
        if (slot_end) begin
          state_d = ((state_q == StAddrAck) && !nack_q) ? StData : StStop;
        end
      end
      StStop: begin
        if (slot_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin levels for the upcoming cycle, decoded from next-state values.
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_d)
      StStart: sda_oe_d = qtr_d[1];
      StAddr, StData: begin
        scl_d    = qtr_d[1];
        sda_oe_d = ~shift_d[15];
      end
      StAddrAck, StDataAck: scl_d = qtr_d[1];
      StStop: begin
        scl_d    = qtr_d[1];
        sda_oe_d = (qtr_d != 2'd3);
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      div_q    <= '0;
      qtr_q    <= 2'd0;
      bit_q    <= 3'd0;
      shift_q  <= 16'd0;
      nack_q   <= 1'b0;
      done_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      nack_q   <= nack_d;
      done_q   <= done_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign nack   = nack_q;
  assign SCL    = scl_q;
  assign SDA_OE = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: open-drain bus with a behavioural slave and a bus-level decoder.
module tb_i2c_master_tx;

  localparam int unsigned D = 4;
  localparam logic [6:0] Addr = 7'b1000111;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       busy, done, nack, SCL, SDA_OE;
  logic       sda_line;
  logic       pull = 1'b0;

  assign sda_line = ~SDA_OE & ~pull;

  i2c_master_tx #(.CLK_DIV(D), .DEV_ADDR(Addr)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .start  (start),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .nack   (nack),
    .SCL    (SCL),
    .SDA_OE (SDA_OE),
    .SDA_IN (sda_line)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Bus decoder and slave: START/STOP detection, SCL-rise bit capture, ACK by falling-edge count.
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  int   fc = 0;
  int   starts = 0;
  int   stops = 0;
  logic bitq[$];
  logic cfg_aa = 1'b1;
  logic cfg_ad = 1'b1;

  always @(negedge CLK) begin
    if (prev_scl && SCL && prev_sda && !sda_line) begin
      starts++;
      fc = 0;
      bitq.delete();
    end
    if (prev_scl && SCL && !prev_sda && sda_line) stops++;
    if (!prev_scl && SCL) bitq.push_back(sda_line);
    if (prev_scl && !SCL) fc++;
    prev_scl = SCL;
    prev_sda = sda_line;
    pull = ((fc == 9) && cfg_aa) || ((fc == 18) && cfg_ad);
  end

  task automatic do_frame(input logic [7:0] d, input logic aa, input logic ad,
                          input bit inject, input bit chained, input string tag);
    int s0, p0, cyc, bad, exp_lat;
    bit got;
    logic exp_nack;
    logic exp_bits[$];
    logic [6:0] a;
    a = Addr;
    cfg_aa = aa;
    cfg_ad = ad;
    if (!chained) @(negedge CLK);
    s0 = starts;
    p0 = stops;
    start = 1'b1;
    din = d;
    @(posedge CLK);
    #1;
    start = 1'b0;
    din = 8'($urandom);
    checks++;
    if (busy !== 1'b1 || nack !== 1'b0) begin
      failures++;
      $display("FAIL %s accept: busy=%b nack=%b required busy=1 nack=0", tag, busy, nack);
    end
    cyc = 0;
    got = 0;
    while (!got && cyc < 100 * D) begin
      start = inject && (cyc == 49);
      if (inject && cyc == 49) din = 8'h00;
      @(posedge CLK);
      #1;
      cyc++;
      if (done === 1'b1) got = 1;
    end
    start = 1'b0;
    exp_nack = !aa || !ad;
    exp_lat = aa ? 80 * D : 44 * D;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, 100 * D);
    end else if (cyc != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d required %0d", tag, cyc, exp_lat);
    end
    checks++;
    if (nack !== exp_nack || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_state: nack=%b busy=%b required nack=%b busy=0",
               tag, nack, busy, exp_nack);
    end
    for (int i = 6; i >= 0; i--) exp_bits.push_back(a[i]);
    exp_bits.push_back(1'b0);
    exp_bits.push_back(!aa);
    if (aa) begin
      for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
      exp_bits.push_back(!ad);
    end
    exp_bits.push_back(1'b0);
    checks++;
    if (bitq.size() != exp_bits.size()) begin
      failures++;
      $display("FAIL %s bit_count: got %0d SCL rises required %0d",
               tag, bitq.size(), exp_bits.size());
    end else begin
      bad = 0;
      for (int i = 0; i < exp_bits.size(); i++) if (bitq[i] !== exp_bits[i]) bad++;
      if (bad != 0) begin
        failures++;
        $display("FAIL %s bits: %0d wrong SDA bits (data %h) required 0", tag, bad, d);
      end
    end
    checks++;
    if (starts - s0 != 1 || stops - p0 != 1) begin
      failures++;
      $display("FAIL %s conditions: starts=%0d stops=%0d required 1 and 1",
               tag, starts - s0, stops - p0);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (SCL !== 1'b1 || SDA_OE !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || nack !== 1'b0) begin
      failures++;
      $display("FAIL reset: SCL=%b SDA_OE=%b busy=%b done=%b nack=%b required 1 0 0 0 0",
               SCL, SDA_OE, busy, done, nack);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(posedge CLK);
  endtask

  task automatic test_basic();
    do_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_addr_nack();
    do_frame(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, "addr_nack");
  endtask

  task automatic test_data_nack();
    int lost;
    do_frame(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "data_nack");
    lost = 0;
    repeat (10) begin
      @(posedge CLK);
      #1;
      if (nack !== 1'b1) lost++;
    end
    checks++;
    if (lost != 0) begin
      failures++;
      $display("FAIL nack_hold: nack low in %0d idle cycles required 0", lost);
    end
  endtask

  task automatic test_ignore_start();
    int extra;
    do_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, "ignore_start");
    extra = 0;
    repeat (8) begin
      @(posedge CLK);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignore_after: done/busy high in %0d cycles required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    cfg_aa = 1'b1;
    cfg_ad = 1'b1;
    @(negedge CLK);
    start = 1'b1;
    din = 8'h5A;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (99) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (SCL !== 1'b1 || SDA_OE !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: SCL=%b SDA_OE=%b busy=%b done=%b required 1 0 0 0",
               SCL, SDA_OE, busy, done);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    dones = 0;
    repeat (400) begin
      @(posedge CLK);
      #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: done/busy seen %0d times required 0", dones);
    end
    do_frame(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_frame(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, "b2b_0");
    do_frame(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b1, "b2b_1");
    do_frame(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b1, "b2b_2");
    do_frame(8'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b1, "b2b_3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_frame(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_nack();
    test_data_nack();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
